// File: rtl/alu_pkg.sv
// alu_pkg: opcodes, sequencer state encoding and instruction field layout
package alu_pkg;
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_ROL = 3'd4;
    localparam logic [2:0] OP_ASR = 3'd5;
    localparam logic [2:0] OP_EQ  = 3'd6;
    localparam logic [2:0] OP_GT  = 3'd7;
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_OPR  = 2'd1,
        S_EXE  = 2'd2,
        S_WB   = 2'd3
    } state_e;
    localparam int OP_LSB = 6;
    localparam int RD_LSB = 4;
    localparam int RS_LSB = 2;
    localparam int RT_LSB = 0;
endpackage

// File: rtl/alu_sequencer_decode_and_execute.sv
// Decode_and_Execute: combinational 4-bit ALU selected by sel
module Decode_and_Execute
    import alu_pkg::*;
(
    input  logic [2:0] sel,
    input  logic [3:0] rs,
    input  logic [3:0] rt,
    output logic [3:0] rd
);
    always_comb begin
        case (sel)
            OP_ADD:  rd = rs + rt;
            OP_SUB:  rd = rs - rt;
            OP_AND:  rd = rs & rt;
            OP_OR:   rd = rs | rt;
            OP_ROL:  rd = {rs[2:0], rs[3]};
            OP_ASR:  rd = {rt[3], rt[3:1]};
            OP_EQ:   rd = {3'b000, rs == rt};
            default: rd = {3'b000, rs > rt};
        endcase
    end
endmodule

// File: rtl/alu_sequencer.sv
// alu_sequencer: four-state fetch/operand/execute/writeback wrapper around
// the ALU with a small register file and a host load port.
module alu_sequencer
    import alu_pkg::*;
#(
    parameter int NREG = 4,
    parameter int W = 4,
    localparam int IW = $clog2(NREG)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [8:0]    in_instr,
    input  logic          ld_en,
    input  logic [IW-1:0] ld_idx,
    input  logic [W-1:0]  ld_data,
    input  logic [IW-1:0] dbg_idx,
    output logic [W-1:0]  dbg_data,
    output logic          done,
    output logic [IW-1:0] res_idx,
    output logic [W-1:0]  res_data,
    output logic [7:0]    retired
);
    state_e        state_q, state_d;
    logic [8:0]    ir_q, ir_d;
    logic [W-1:0]  opa_q, opa_d, opb_q, opb_d, res_q, res_d, alu_y;
    logic [W-1:0]  regs_q [NREG];
    logic [W-1:0]  regs_d [NREG];
    logic          done_q, done_d;
    logic [7:0]    retired_q, retired_d;
    logic [IW-1:0] rd, rs, rt;

    assign rd = ir_q[RD_LSB +: IW];
    assign rs = ir_q[RS_LSB +: IW];
    assign rt = ir_q[RT_LSB +: IW];
    assign in_ready = state_q == S_IDLE;
    assign dbg_data = regs_q[dbg_idx];
    assign done = done_q;
    assign res_idx = rd;
    assign res_data = res_q;
    assign retired = retired_q;

    Decode_and_Execute u_alu (
        .sel(ir_q[OP_LSB +: 3]),
        .rs (opa_q),
        .rt (opb_q),
        .rd (alu_y)
    );

    always_comb begin
        state_d = state_q;
        ir_d = ir_q;
        opa_d = opa_q;
        opb_d = opb_q;
        res_d = res_q;
        regs_d = regs_q;
        done_d = 1'b0;
        retired_d = retired_q;
        if (ld_en) regs_d[ld_idx] = ld_data;
        case (state_q)
            S_IDLE: if (in_valid) begin
                ir_d = in_instr;
                state_d = S_OPR;
            end
            S_OPR: begin
                opa_d = regs_q[rs];
                opb_d = regs_q[rt];
                state_d = S_EXE;
            end
            S_EXE: begin
                res_d = alu_y;
                done_d = 1'b1;
                state_d = S_WB;
            end
            S_WB: begin
                // assigned after the load so writeback wins a same-index conflict
                regs_d[rd] = res_q;
                retired_d = retired_q + 8'd1;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ir_q <= '0;
            opa_q <= '0;
            opb_q <= '0;
            res_q <= '0;
            regs_q <= '{default: '0};
            done_q <= 1'b0;
            retired_q <= '0;
        end else begin
            state_q <= state_d;
            ir_q <= ir_d;
            opa_q <= opa_d;
            opb_q <= opb_d;
            res_q <= res_d;
            regs_q <= regs_d;
            done_q <= done_d;
            retired_q <= retired_d;
        end
    end
endmodule

// File: tb/tb_alu_sequencer.sv
// tb_alu_sequencer: directed vectors with hand-computed results for alu_sequencer
module tb_alu_sequencer;
    import alu_pkg::*;
    logic       clk = 0, rst = 1, in_valid = 0, ld_en = 0;
    logic [8:0] in_instr = '0;
    logic [1:0] ld_idx = '0, dbg_idx = '0, res_idx;
    logic [3:0] ld_data = '0, dbg_data, res_data;
    logic       in_ready, done;
    logic [7:0] retired;
    int n_chk = 0, n_fail = 0, cyc = 0;
    int a1, a2, a3, dummy;

    alu_sequencer dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .in_instr(in_instr), .ld_en(ld_en), .ld_idx(ld_idx), .ld_data(ld_data),
        .dbg_idx(dbg_idx), .dbg_data(dbg_data), .done(done), .res_idx(res_idx),
        .res_data(res_data), .retired(retired)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic dbg(input logic [1:0] i, input logic [3:0] e, input string tag);
        dbg_idx = i;
        #1;
        chk(tag, dbg_data, e);
    endtask

    task automatic load(input logic [1:0] i, input logic [3:0] d);
        ld_en = 1; ld_idx = i; ld_data = d;
        @(negedge clk);
        ld_en = 0;
    endtask

    // ld_at selects the edge (1=OPR, 2=EXE, 3=WB) that carries a host load;
    // junk keeps in_valid high with a different instruction while busy
    task automatic run(input logic [2:0] op, input logic [1:0] rd, input logic [1:0] rs,
                       input logic [1:0] rt, input logic [3:0] exp, input string tag,
                       input int ld_at, input logic [1:0] li, input logic [3:0] lv,
                       input bit junk, output int acc);
        int t = 0;
        while (!in_ready && t < 20) begin @(negedge clk); t++; end
        chk({tag, "_ready"}, in_ready, 1);
        in_valid = 1; in_instr = {op, rd, rs, rt};
        @(negedge clk);
        acc = cyc;
        chk({tag, "_accept"}, in_ready, 0);
        for (int k = 1; k <= 3; k++) begin
            in_valid = junk; in_instr = ~{op, rd, rs, rt};
            ld_en = (ld_at == k); ld_idx = li; ld_data = lv;
            @(negedge clk);
            if (k == 1) chk({tag, "_early_done"}, done, 0);
            if (k == 2) begin
                chk({tag, "_done"}, done, 1);
                chk({tag, "_res_idx"}, res_idx, rd);
                chk({tag, "_res_data"}, res_data, exp);
            end
            if (k == 3) begin
                chk({tag, "_done_pulse"}, done, 0);
                chk({tag, "_ready_back"}, in_ready, 1);
            end
        end
        in_valid = 0; ld_en = 0;
    endtask

    initial begin
        @(negedge clk); @(negedge clk);
        rst = 0;
        chk("rst_ready", in_ready, 1);
        chk("rst_done", done, 0);
        chk("rst_retired", retired, 0);
        chk("rst_res_idx", res_idx, 0);
        chk("rst_res_data", res_data, 0);
        for (int i = 0; i < 4; i++) dbg(i[1:0], 4'h0, "rst_reg");

        load(0, 9); load(1, 8);
        run(OP_ADD, 2, 0, 1, 4'h1, "add", 0, 0, 0, 0, dummy);
        dbg(2, 4'h1, "add_wb");
        chk("add_retired", retired, 1);

        load(0, 3); load(1, 5);
        run(OP_SUB, 2, 0, 1, 4'hE, "sub", 0, 0, 0, 0, a1);
        run(OP_GT,  3, 0, 1, 4'h0, "gt",  2, 0, 9, 0, a2);
        run(OP_ROL, 1, 0, 0, 4'h3, "rol", 0, 0, 0, 0, a3);
        chk("b2b_gap1", a2 - a1, 4);
        chk("b2b_gap2", a3 - a2, 4);
        dbg(2, 4'hE, "sub_wb");
        dbg(1, 4'h3, "rol_wb");

        run(OP_OR, 3, 2, 1, 4'hF, "junk", 0, 0, 0, 1, dummy);
        dbg(0, 4'h9, "junk_r0");
        dbg(3, 4'hF, "junk_r3");
        chk("junk_retired", retired, 5);

        run(OP_ADD, 3, 0, 0, 4'h2, "opr_ld", 1, 0, 1, 0, dummy);
        dbg(0, 4'h1, "opr_ld_r0");
        dbg(3, 4'h2, "opr_ld_r3");

        run(OP_AND, 2, 1, 0, 4'h1, "conf_same", 3, 2, 7, 0, dummy);
        dbg(2, 4'h1, "conf_same_r2");
        run(OP_AND, 2, 1, 0, 4'h1, "conf_diff", 3, 3, 7, 0, dummy);
        dbg(2, 4'h1, "conf_diff_r2");
        dbg(3, 4'h7, "conf_diff_r3");

        load(0, 8);
        run(OP_ASR, 1, 2, 0, 4'hC, "asr", 0, 0, 0, 0, dummy);
        run(OP_EQ,  2, 0, 0, 4'h1, "eq",  0, 0, 0, 0, dummy);
        chk("pre_rst_retired", retired, 10);

        in_valid = 1; in_instr = {OP_ADD, 2'd2, 2'd0, 2'd1};
        @(negedge clk);
        in_valid = 0;
        @(negedge clk);
        rst = 1; ld_en = 1; ld_idx = 1; ld_data = 5;
        @(negedge clk);
        rst = 0; ld_en = 0;
        chk("abort_ready", in_ready, 1);
        for (int i = 0; i < 4; i++) begin
            chk("abort_done", done, 0);
            @(negedge clk);
        end
        dbg(2, 4'h0, "abort_r2");
        dbg(1, 4'h0, "abort_ld_prio");
        chk("abort_retired", retired, 0);

        begin
            int dones = 0, t = 0;
            in_valid = 1; in_instr = {OP_ADD, 2'd0, 2'd0, 2'd0};
            while (dones < 256 && t < 2000) begin
                @(negedge clk);
                t++;
                if (done) begin
                    dones++;
                    if (dones == 256) begin
                        chk("wrap_pre", retired, 255);
                        in_valid = 0;
                    end
                end
            end
            in_valid = 0;
            chk("wrap_count", dones, 256);
            @(negedge clk);
            chk("wrap", retired, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
